// File: rtl/video_clk_sequencer.sv
// Video PLL bring-up sequencer: pulses PLL reset, waits for lock with timeout/retry,
// qualifies lock stability, then releases pixel-domain and serializer resets in order.
module video_clk_sequencer #(
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned STAGGER_CYCLES      = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       pll_locked_i,
   output logic       pll_rst_o,
   output logic       video_rst_n_o,
   output logic       hdmi_rst_n_o,
   output logic       ready_o,
   output logic       lock_lost_o,
   output logic [7:0] retry_count_o
);

   localparam int unsigned MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                   PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned MAX_B = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                                   LOCK_STABLE_CYCLES : STAGGER_CYCLES;
   localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] STG_LAST = CW'(STAGGER_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      REL_VIDEO,
      RUN
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          lk_m, lk_s;
   logic          retry_inc;
   logic          lost_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lk_m <= 1'b0;
         lk_s <= 1'b0;
      end else begin
         lk_m <= pll_locked_i;
         lk_s <= lk_m;
      end
   end

   // In STABLE, cnt==0 on the entry cycle stands for the first qualified lock cycle.
   always_comb begin
      state_nxt = state;
      retry_inc = 1'b0;
      lost_nxt  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      state_nxt = PLL_RST;
            PLL_RST:   if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lk_s) begin
                  state_nxt = STABLE;
               end else if (cnt == TO_LAST) begin
                  state_nxt = PLL_RST;
                  retry_inc = 1'b1;
               end
            end
            STABLE: begin
               if (!lk_s)                 state_nxt = WAIT_LOCK;
               else if (cnt == STB_LAST)  state_nxt = REL_VIDEO;
            end
            REL_VIDEO: begin
               if (!lk_s)                 state_nxt = PLL_RST;
               else if (cnt == STG_LAST)  state_nxt = RUN;
            end
            RUN: begin
               if (!lk_s) begin
                  state_nxt = PLL_RST;
                  lost_nxt  = 1'b1;
               end
            end
            default:   state_nxt = IDLE;
         endcase
      end
      cnt_nxt = ((state_nxt != state) || (state_nxt == IDLE)) ? '0 : cnt + CW'(1);
   end

   // Outputs are decoded from the next state so they align with the state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         cnt           <= '0;
         pll_rst_o     <= 1'b1;
         video_rst_n_o <= 1'b0;
         hdmi_rst_n_o  <= 1'b0;
         ready_o       <= 1'b0;
         lock_lost_o   <= 1'b0;
         retry_count_o <= '0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         pll_rst_o     <= (state_nxt == IDLE) || (state_nxt == PLL_RST);
         video_rst_n_o <= (state_nxt == REL_VIDEO) || (state_nxt == RUN);
         hdmi_rst_n_o  <= (state_nxt == RUN);
         ready_o       <= (state_nxt == RUN);
         lock_lost_o   <= lost_nxt;
         if (retry_inc && (retry_count_o != '1))
            retry_count_o <= retry_count_o + 8'd1;
      end
   end

endmodule
